// File: rtl/bist_pkg.sv
// Shared types and default sizing for the BIST session sequencer.
package bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INIT    = 3'd1,
    S_RUN     = 3'd2,
    S_SETTLE  = 3'd3,
    S_COMPARE = 3'd4,
    S_DONE    = 3'd5
  } bist_state_e;

  localparam int DEF_SIG_W       = 5;
  localparam int DEF_CNT_W       = 11;
  localparam int DEF_PATTERN_CNT = 1024;

endpackage

// File: rtl/bist_pattern_counter.sv
// Phase bit and pattern counter for a BIST session; two steps per pattern.
module bist_pattern_counter #(
  parameter int CNT_W       = 11,
  parameter int PATTERN_CNT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             step,
  output logic             phase,
  output logic [CNT_W-1:0] pattern_idx,
  output logic             last
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      phase       <= 1'b0;
      pattern_idx <= '0;
    end else if (clr) begin
      phase       <= 1'b0;
      pattern_idx <= '0;
    end else if (step) begin
      phase <= ~phase;
      if (phase) pattern_idx <= pattern_idx + CNT_W'(1);
    end
  end

  // Asserted during the phase1 step that completes the final pattern.
  assign last = step && phase && (pattern_idx == CNT_W'(PATTERN_CNT - 1));

endmodule

// File: rtl/bist_sequencer.sv
// BIST session sequencer: LFSR/MISR clear, pattern stepping, signature compare.
// Optional abort input enabled by defining BIST_ABORT_EN.
module bist_sequencer
  import bist_pkg::*;
#(
  parameter int               PATTERN_CNT = DEF_PATTERN_CNT,
  parameter int               CNT_W       = DEF_CNT_W,
  parameter int               SIG_W       = DEF_SIG_W,
  parameter logic [SIG_W-1:0] GOLDEN_SIG  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef BIST_ABORT_EN
  input  logic             abort,
`endif
  input  logic [SIG_W-1:0] signature,
  output logic             lfsr_clr,
  output logic             lfsr_en,
  output logic             misr_clr,
  output logic             misr_en,
  output logic             half_sel,
  output logic [CNT_W-1:0] pattern_idx,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] captured_sig,
  output bist_state_e      state
);

  bist_state_e state_next;
  logic        cnt_clr;
  logic        cnt_step;
  logic        phase;
  logic        last;
  logic        capture;
  logic        abort_hit;
  logic        abort_capture;

`ifdef BIST_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  bist_pattern_counter #(
    .CNT_W       (CNT_W),
    .PATTERN_CNT (PATTERN_CNT)
  ) u_counter (
    .clk         (clk),
    .rst         (rst),
    .clr         (cnt_clr),
    .step        (cnt_step),
    .phase       (phase),
    .pattern_idx (pattern_idx),
    .last        (last)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next    = state;
    lfsr_clr      = 1'b0;
    lfsr_en       = 1'b0;
    misr_clr      = 1'b0;
    misr_en       = 1'b0;
    half_sel      = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    cnt_clr       = 1'b0;
    cnt_step      = 1'b0;
    capture       = 1'b0;
    abort_capture = 1'b0;
    case (state)
      S_IDLE: if (start) state_next = S_INIT;
      S_INIT: begin
        lfsr_clr   = 1'b1;
        misr_clr   = 1'b1;
        busy       = 1'b1;
        cnt_clr    = 1'b1;
        state_next = S_RUN;
      end
      S_RUN: begin
        busy     = 1'b1;
        misr_en  = 1'b1;
        half_sel = ~phase;
        lfsr_en  = phase;
        cnt_step = 1'b1;
        if (last) state_next = S_SETTLE;
      end
      S_SETTLE: begin
        busy       = 1'b1;
        state_next = S_COMPARE;
      end
      S_COMPARE: begin
        busy       = 1'b1;
        capture    = 1'b1;
        state_next = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_next = S_INIT;
      end
      default: state_next = S_IDLE;
    endcase
    // Abort ends any active session immediately, with every datapath enable dropped.
    if (abort_hit && busy) begin
      state_next    = S_DONE;
      lfsr_clr      = 1'b0;
      misr_clr      = 1'b0;
      lfsr_en       = 1'b0;
      misr_en       = 1'b0;
      half_sel      = 1'b0;
      cnt_clr       = 1'b0;
      cnt_step      = 1'b0;
      capture       = 1'b0;
      abort_capture = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pass         <= 1'b0;
      captured_sig <= '0;
    end else if (abort_capture) begin
      pass         <= 1'b0;
      captured_sig <= signature;
    end else if (capture) begin
      pass         <= (signature == GOLDEN_SIG);
      captured_sig <= signature;
    end else if (state == S_DONE && start) begin
      pass         <= 1'b0;
      captured_sig <= '0;
    end
  end

endmodule

// File: tb/tb_bist_sequencer.sv
// Self-checking bench for bist_sequencer (PATTERN_CNT=4, GOLDEN_SIG=5'h13).
module tb_bist_sequencer;
  import bist_pkg::*;

  localparam int          P    = 4;
  localparam int          CW   = 11;
  localparam int          SW   = 5;
  localparam logic [4:0]  GOLD = 5'h13;
  localparam int          VW   = 3 + 7 + 1 + SW + 1 + CW;

  logic          clk;
  logic          rst;
  logic          start;
  logic          abort;
  logic [SW-1:0] signature;
  logic          lfsr_clr, lfsr_en, misr_clr, misr_en, half_sel;
  logic [CW-1:0] pattern_idx;
  logic          busy, done, pass;
  logic [SW-1:0] captured_sig;
  bist_state_e   state;

  logic [VW-1:0] exp_q[$];
  int tests;
  int fails;

  bist_sequencer #(
    .PATTERN_CNT (P),
    .CNT_W       (CW),
    .SIG_W       (SW),
    .GOLDEN_SIG  (GOLD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
`ifdef BIST_ABORT_EN
    .abort        (abort),
`endif
    .signature    (signature),
    .lfsr_clr     (lfsr_clr),
    .lfsr_en      (lfsr_en),
    .misr_clr     (misr_clr),
    .misr_en      (misr_en),
    .half_sel     (half_sel),
    .pattern_idx  (pattern_idx),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .captured_sig (captured_sig),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] ctrl_now();
    return {lfsr_clr, misr_clr, lfsr_en, misr_en, half_sel, busy, done};
  endfunction

  // Expected vector: {state, ctrl, pass, captured_sig, idx_care, pattern_idx}.
  function automatic logic [VW-1:0] mk(input logic [2:0] st, input logic [6:0] c,
                                       input logic ps, input logic [SW-1:0] cap,
                                       input logic care, input int idx);
    return {st, c, ps, cap, care, CW'(idx)};
  endfunction

  task automatic wait_cycle();
    @(posedge clk);
    #1;
  endtask

  // Drives one session from the current cycle and checks every cycle up to the first DONE.
  task automatic run_session(input logic [SW-1:0] sig, input bit keep_start, input string name);
    logic [VW-1:0] e;
    int n;
    signature = sig;
    start = 1'b1;
    exp_q.push_back(mk(S_INIT, 7'b1100010, 1'b0, '0, 1'b0, 0));
    for (int i = 0; i < 2 * P; i++)
      exp_q.push_back(mk(S_RUN, {2'b00, 1'(i % 2), 1'b1, 1'(1 - (i % 2)), 2'b10},
                         1'b0, '0, 1'b1, i / 2));
    exp_q.push_back(mk(S_SETTLE, 7'b0000010, 1'b0, '0, 1'b1, P));
    exp_q.push_back(mk(S_COMPARE, 7'b0000010, 1'b0, '0, 1'b1, P));
    exp_q.push_back(mk(S_DONE, 7'b0000001, sig == GOLD, sig, 1'b1, P));
    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      wait_cycle();
      if (!keep_start) start = 1'b0;
      e = exp_q.pop_front();
      tests++;
      if (state !== bist_state_e'(e[VW-1 -: 3]) || ctrl_now() !== e[VW-4 -: 7] ||
          pass !== e[SW+CW+1] || captured_sig !== e[CW+1 +: SW] ||
          (e[CW] && pattern_idx !== e[CW-1:0])) begin
        fails++;
        $display("FAIL %s cycle %0d: got st=%0d ctrl=%b pass=%b sig=%h idx=%0d, exp st=%0d ctrl=%b pass=%b sig=%h idx=%0d(care=%b)",
                 name, k, state, ctrl_now(), pass, captured_sig, pattern_idx,
                 e[VW-1 -: 3], e[VW-4 -: 7], e[SW+CW+1], e[CW+1 +: SW], e[CW-1:0], e[CW]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b1;
    abort = 1'b0;
    signature = 5'h1f;
    for (int i = 0; i < 3; i++) begin
      wait_cycle();
      tests++;
      if (state !== S_IDLE || ctrl_now() !== 7'b0 || pass !== 1'b0 ||
          captured_sig !== '0 || pattern_idx !== '0) begin
        fails++;
        $display("FAIL reset cycle %0d: st=%0d ctrl=%b pass=%b sig=%h idx=%0d, exp all 0",
                 i, state, ctrl_now(), pass, captured_sig, pattern_idx);
      end
    end
    start = 1'b0;
    rst = 1'b1;
    wait_cycle();
    tests++;
    if (state !== S_IDLE || ctrl_now() !== 7'b0) begin
      fails++;
      $display("FAIL idle_hold: st=%0d ctrl=%b, exp IDLE/0", state, ctrl_now());
    end
  endtask

  task automatic test_normal();
    run_session(GOLD, 1'b0, "normal");
  endtask

  task automatic test_mismatch();
    logic [SW-1:0] sig;
    run_session(5'h12, 1'b0, "mismatch");
    signature = 5'(($urandom_range(0, 30) + 1 + 5'h12) % 32);
    sig = 5'h12;
    for (int i = 0; i < 3; i++) begin
      wait_cycle();
      tests++;
      if (done !== 1'b1 || pass !== 1'b0 || captured_sig !== sig || busy !== 1'b0) begin
        fails++;
        $display("FAIL done_hold cycle %0d: done=%b pass=%b sig=%h busy=%b, exp 1/0/%h/0",
                 i, done, pass, captured_sig, busy, sig);
      end
    end
  endtask

  task automatic test_back_to_back();
    run_session(GOLD, 1'b1, "hold_start");
    run_session(5'(($urandom_range(0, 31))), 1'b0, "restart");
  endtask

  task automatic test_mid_reset();
    int budget;
    signature = GOLD;
    start = 1'b1;
    budget = 0;
    do begin
      wait_cycle();
      start = 1'b0;
      budget++;
    end while (!(state == S_RUN && pattern_idx == CW'(2)) && budget < 20);
    tests++;
    if (budget >= 20) begin
      fails++;
      $display("FAIL mid_reset_reach: idx=%0d st=%0d, exp idx 2 in RUN", pattern_idx, state);
    end
    rst = 1'b0;
    wait_cycle();
    rst = 1'b1;
    tests++;
    if (state !== S_IDLE || ctrl_now() !== 7'b0 || pattern_idx !== '0 ||
        pass !== 1'b0 || captured_sig !== '0) begin
      fails++;
      $display("FAIL mid_reset: st=%0d ctrl=%b idx=%0d pass=%b sig=%h, exp all 0",
               state, ctrl_now(), pattern_idx, pass, captured_sig);
    end
    run_session(GOLD, 1'b0, "after_reset");
  endtask

`ifdef BIST_ABORT_EN
  task automatic test_abort();
    int budget;
    signature = 5'h0a;
    start = 1'b1;
    budget = 0;
    do begin
      wait_cycle();
      start = 1'b0;
      budget++;
    end while (!(state == S_RUN && pattern_idx == CW'(1)) && budget < 20);
    abort = 1'b1;
    wait_cycle();
    abort = 1'b0;
    tests++;
    if (state !== S_DONE || done !== 1'b1 || pass !== 1'b0 || captured_sig !== 5'h0a ||
        lfsr_en !== 1'b0 || misr_en !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL abort: st=%0d done=%b pass=%b sig=%h lfsr_en=%b misr_en=%b busy=%b",
               state, done, pass, captured_sig, lfsr_en, misr_en, busy);
    end
    run_session(GOLD, 1'b0, "after_abort");
  endtask
`endif

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    signature = '0;
    test_reset();
    test_normal();
    test_mismatch();
    test_back_to_back();
    test_mid_reset();
`ifdef BIST_ABORT_EN
    test_abort();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
